// File: rtl/usb_rx_framer.sv
// FT245 FIFO reader and frame parser: sync byte, row/panel address byte, then payload packed into chunk writes.
// Define USB_RX_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
`timescale 1ns/1ps
module usb_rx_framer #(
  parameter int         CHUNK_BYTES    = 4,
  parameter int         CHUNKS_PER_ROW = 16,
  parameter int         ROW_ADDR_W     = 4,
  parameter int         PANEL_ADDR_W   = 2,
  parameter int         RD_PULSE       = 3,
  parameter int         RD_GAP         = 2,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              rxf_n_raw,
  input  logic [7:0]                        data_bus_in_raw,
  output logic                              rd_n,
  output logic [8*CHUNK_BYTES-1:0]          chunk_data,
  output logic [$clog2(CHUNKS_PER_ROW)-1:0] chunk_addr,
  output logic                              chunk_write_enable,
  output logic [ROW_ADDR_W-1:0]             row_addr,
  output logic [PANEL_ADDR_W-1:0]           panel_addr,
  output logic                              frame_done,
  output logic                              frame_error,
  output logic [2:0]                        state_out
);
  localparam int DW     = 8 * CHUNK_BYTES;
  localparam int CA_W   = $clog2(CHUNKS_PER_ROW);
  localparam int BC_W   = (CHUNK_BYTES > 1) ? $clog2(CHUNK_BYTES) : 1;
  localparam int AW     = ROW_ADDR_W + PANEL_ADDR_W;
  localparam int RC_MAX = (RD_PULSE > RD_GAP) ? RD_PULSE : RD_GAP;
  localparam int RC_W   = $clog2(RC_MAX);
  localparam logic [RC_W-1:0] PULSE_LAST = RC_W'(RD_PULSE - 1);
  localparam logic [RC_W-1:0] GAP_LAST   = RC_W'(RD_GAP - 1);
  localparam logic [BC_W-1:0] BYTE_LAST  = BC_W'(CHUNK_BYTES - 1);
  localparam logic [CA_W-1:0] CHUNK_LAST = CA_W'(CHUNKS_PER_ROW - 1);

  typedef enum logic [1:0] {RS_IDLE, RS_LOW, RS_HIGH} rd_state_t;
  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CKSUM   = 3'd3,
    ST_DONE    = 3'd4
  } fr_state_t;

  logic            r_rxf_s1, r_rxf_s2;
  logic [7:0]      r_dat_s1, r_dat_s2;
  rd_state_t       r_rs, w_rs_nxt;
  logic [RC_W-1:0] r_rc, w_rc_nxt;
  logic            r_rd_n;
  logic            w_byte_vld;
  logic [7:0]      w_byte;

  fr_state_t         r_fr, w_fr_nxt;
  logic [DW-1:0]     r_chunk, w_shift_dat;
  logic [BC_W-1:0]   r_byte_cnt;
  logic [CA_W-1:0]   r_chunk_cnt;
  logic [ROW_ADDR_W-1:0]   r_row;
  logic [PANEL_ADDR_W-1:0] r_panel;
  logic              r_we, r_err;
  logic              w_addr_ld, w_shift, w_we_nxt, w_err_nxt, w_chunk_inc, w_addr_hi_ok;
`ifdef USB_RX_CHECKSUM_EN
  logic [7:0]        r_cksum;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rxf_s1 <= 1'b1;
      r_rxf_s2 <= 1'b1;
      r_dat_s1 <= 8'h00;
      r_dat_s2 <= 8'h00;
    end else begin
      r_rxf_s1 <= rxf_n_raw;
      r_rxf_s2 <= r_rxf_s1;
      r_dat_s1 <= data_bus_in_raw;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Data is taken from the synchroniser on the last low cycle; that same edge releases rd_n.
  always_comb begin
    w_rs_nxt   = r_rs;
    w_rc_nxt   = r_rc;
    w_byte_vld = 1'b0;
    case (r_rs)
      RS_IDLE: if (!r_rxf_s2) begin
        w_rs_nxt = RS_LOW;
        w_rc_nxt = '0;
      end
      RS_LOW: if (r_rc == PULSE_LAST) begin
        w_byte_vld = 1'b1;
        w_rs_nxt   = RS_HIGH;
        w_rc_nxt   = '0;
      end else begin
        w_rc_nxt = r_rc + 1'b1;
      end
      RS_HIGH: if (r_rc == GAP_LAST) begin
        w_rs_nxt = RS_IDLE;
        w_rc_nxt = '0;
      end else begin
        w_rc_nxt = r_rc + 1'b1;
      end
      default: w_rs_nxt = RS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rs   <= RS_IDLE;
      r_rc   <= '0;
      r_rd_n <= 1'b1;
    end else begin
      r_rs   <= w_rs_nxt;
      r_rc   <= w_rc_nxt;
      r_rd_n <= (w_rs_nxt != RS_LOW);
    end
  end

  assign w_byte       = r_dat_s2;
  assign w_addr_hi_ok = ((w_byte >> AW) == 8'h00);

  if (CHUNK_BYTES > 1) begin : g_shift
    assign w_shift_dat = {r_chunk[DW-9:0], w_byte};
  end else begin : g_shift1
    assign w_shift_dat = w_byte;
  end

  always_comb begin
    w_fr_nxt    = r_fr;
    w_addr_ld   = 1'b0;
    w_shift     = 1'b0;
    w_we_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    w_chunk_inc = 1'b0;
    case (r_fr)
      ST_HUNT: if (w_byte_vld && (w_byte == SYNC_BYTE)) w_fr_nxt = ST_ADDR;
      ST_ADDR: if (w_byte_vld) begin
        if (w_addr_hi_ok) begin
          w_addr_ld = 1'b1;
          w_fr_nxt  = ST_PAYLOAD;
        end else begin
          w_err_nxt = 1'b1;
          w_fr_nxt  = ST_HUNT;
        end
      end
      ST_PAYLOAD: begin
        if (w_byte_vld) begin
          w_shift  = 1'b1;
          w_we_nxt = (r_byte_cnt == BYTE_LAST);
        end
        // The chunk index advances at the end of its strobe cycle.
        if (r_we) begin
          w_chunk_inc = 1'b1;
          if (r_chunk_cnt == CHUNK_LAST) begin
`ifdef USB_RX_CHECKSUM_EN
            w_fr_nxt = ST_CKSUM;
`else
            w_fr_nxt = ST_DONE;
`endif
          end
        end
      end
`ifdef USB_RX_CHECKSUM_EN
      ST_CKSUM: if (w_byte_vld) begin
        if (w_byte == r_cksum) begin
          w_fr_nxt = ST_DONE;
        end else begin
          w_err_nxt = 1'b1;
          w_fr_nxt  = ST_HUNT;
        end
      end
`else
      ST_CKSUM: w_fr_nxt = ST_HUNT;
`endif
      ST_DONE: w_fr_nxt = ST_HUNT;
      default: w_fr_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fr        <= ST_HUNT;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_chunk     <= '0;
      r_byte_cnt  <= '0;
      r_chunk_cnt <= '0;
      r_row       <= '0;
      r_panel     <= '0;
`ifdef USB_RX_CHECKSUM_EN
      r_cksum     <= 8'h00;
`endif
    end else begin
      r_fr  <= w_fr_nxt;
      r_we  <= w_we_nxt;
      r_err <= w_err_nxt;
      if (w_addr_ld) begin
        r_row       <= w_byte[ROW_ADDR_W-1:0];
        r_panel     <= w_byte[AW-1:ROW_ADDR_W];
        r_byte_cnt  <= '0;
        r_chunk_cnt <= '0;
`ifdef USB_RX_CHECKSUM_EN
        r_cksum     <= w_byte;
`endif
      end
      if (w_shift) begin
        r_chunk    <= w_shift_dat;
        r_byte_cnt <= (r_byte_cnt == BYTE_LAST) ? '0 : r_byte_cnt + 1'b1;
`ifdef USB_RX_CHECKSUM_EN
        r_cksum    <= r_cksum ^ w_byte;
`endif
      end
      if (w_chunk_inc) r_chunk_cnt <= r_chunk_cnt + 1'b1;
    end
  end

  assign rd_n               = r_rd_n;
  assign chunk_data         = r_chunk;
  assign chunk_addr         = r_chunk_cnt;
  assign chunk_write_enable = r_we;
  assign row_addr           = r_row;
  assign panel_addr         = r_panel;
  assign frame_done         = (r_fr == ST_DONE);
  assign frame_error        = r_err;
  assign state_out          = r_fr;
endmodule

// File: tb/tb_usb_rx_framer.sv
// Bench for usb_rx_framer: FT245 FIFO model, table-driven frames, hand sequences and randomized streams
// checked against a list-walking frame model.
`timescale 1ns/1ps
module tb_usb_rx_framer;
  localparam int         CB   = 4;
  localparam int         CPR  = 16;
  localparam int         RW   = 4;
  localparam int         PW   = 2;
  localparam int         RDP  = 3;
  localparam int         RDG  = 2;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rxf_n_raw;
  logic [7:0]  data_bus_in_raw;
  logic        rd_n;
  logic [31:0] chunk_data;
  logic [3:0]  chunk_addr;
  logic        chunk_write_enable;
  logic [3:0]  row_addr;
  logic [1:0]  panel_addr;
  logic        frame_done;
  logic        frame_error;
  logic [2:0]  state_out;

  usb_rx_framer dut (
    .clk(clk), .reset_n(reset_n), .rxf_n_raw(rxf_n_raw), .data_bus_in_raw(data_bus_in_raw),
    .rd_n(rd_n), .chunk_data(chunk_data), .chunk_addr(chunk_addr),
    .chunk_write_enable(chunk_write_enable), .row_addr(row_addr), .panel_addr(panel_addr),
    .frame_done(frame_done), .frame_error(frame_error), .state_out(state_out)
  );

  always #10 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [3:0] addr; logic [31:0] data; logic [3:0] row; logic [1:0] panel; } wr_t;
  typedef struct { logic [7:0] addr; bit ok; logic [3:0] row; logic [1:0] panel; } vec_t;

  wr_t obs_wr[$], exp_wr[$];
  int  obs_ev[$], exp_ev[$];

  logic [7:0] fifo_q[$];
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_head  = 8'h00;
  int         pause_left = 0;
  int         pause_at   = -1;
  assign rxf_n_raw       = (pause_left != 0) || fifo_empty;
  assign data_bus_in_raw = fifo_head;

  int total = 0, bad = 0;
  int cyc = 0, pops = 0, falls = 0, last_we_cyc = -10;
  int low_run = 0, high_run = 0;
  bit prev_rd = 1'b1, prev_we = 1'b0, seen_read = 1'b0, rd_rise;
  bit bad_state = 1'b0, both_seen = 1'b0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic push_bytes(input bq_t b);
    foreach (b[i]) fifo_q.push_back(b[i]);
    fifo_empty = (fifo_q.size() == 0);
    fifo_head  = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  // FIFO model plus protocol monitor, sampled away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (pause_left > 0) pause_left--;
    if (!reset_n) begin
      prev_rd = 1'b1; prev_we = 1'b0; low_run = 0; high_run = 0; seen_read = 1'b0;
    end else begin
      rd_rise = !prev_rd && rd_n;
      if (!rd_n) begin
        if (prev_rd) begin
          falls++;
          if (seen_read) check("rd_gap_min", 64'(high_run >= RDG), 64'(1));
        end
        low_run++;
      end else begin
        if (rd_rise) begin
          check("rd_pulse_len", 64'(low_run), 64'(RDP));
          low_run = 0; high_run = 0; seen_read = 1'b1;
          if (fifo_q.size() > 0) void'(fifo_q.pop_front());
          fifo_empty = (fifo_q.size() == 0);
          fifo_head  = fifo_empty ? 8'h00 : fifo_q[0];
          pops++;
          if (pops == pause_at) pause_left = 50;
        end
        high_run++;
      end
      if (chunk_write_enable) begin
        obs_wr.push_back('{chunk_addr, chunk_data, row_addr, panel_addr});
        check("we_one_cycle_after_capture", 64'(rd_rise), 64'(1));
        check("we_single_cycle", 64'(prev_we), 64'(0));
        last_we_cyc = cyc;
      end
      if (frame_done) begin
        obs_ev.push_back(0);
`ifndef USB_RX_CHECKSUM_EN
        check("done_after_last_we", 64'(cyc - last_we_cyc), 64'(1));
`endif
      end
      if (frame_error) obs_ev.push_back(1);
      if (frame_done && frame_error) both_seen = 1'b1;
      if (state_out > 3'd4) bad_state = 1'b1;
`ifndef USB_RX_CHECKSUM_EN
      if (state_out == 3'd3) bad_state = 1'b1;
`endif
      prev_we = chunk_write_enable;
      prev_rd = rd_n;
    end
  end

  task automatic model(input bq_t s);
    int i = 0;
    logic [7:0]  a, ck;
    logic [31:0] d;
    while (i < s.size()) begin
      if (s[i] != SYNC) begin i++; continue; end
      if (i + 1 >= s.size()) break;
      a = s[i+1];
      i += 2;
      if ((a >> (RW + PW)) != 8'h00) begin exp_ev.push_back(1); continue; end
      if (i + CB*CPR > s.size()) break;
      ck = a;
      for (int c = 0; c < CPR; c++) begin
        d = 32'h0;
        for (int k = 0; k < CB; k++) begin
          d  = (d << 8) | 32'(s[i + c*CB + k]);
          ck = ck ^ s[i + c*CB + k];
        end
        exp_wr.push_back('{4'(c), d, a[RW-1:0], a[RW+PW-1:RW]});
      end
      i += CB*CPR;
`ifdef USB_RX_CHECKSUM_EN
      if (i >= s.size()) break;
      exp_ev.push_back((s[i] == ck) ? 0 : 1);
      i++;
`else
      exp_ev.push_back(0);
`endif
    end
  endtask

  task automatic wait_drain(input int budget, input bit rnd);
    int n = 0;
    while (!fifo_empty && n < budget) begin
      @(negedge clk);
      n++;
      if (rnd && pause_left == 0 && $urandom_range(0, 199) == 0) pause_left = $urandom_range(5, 40);
    end
    check("drain_timeout", 64'(fifo_q.size()), 64'(0));
    repeat (12) @(negedge clk);
  endtask

  task automatic run_seg(input bq_t s, input bit rnd);
    obs_wr.delete(); obs_ev.delete(); exp_wr.delete(); exp_ev.delete();
    model(s);
    push_bytes(s);
    wait_drain(20 * s.size() + 3000, rnd);
    check("n_writes", 64'(obs_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      check("wr_addr", 64'(obs_wr[i].addr), 64'(exp_wr[i].addr));
      check("wr_data", 64'(obs_wr[i].data), 64'(exp_wr[i].data));
      check("wr_row_panel", 64'({obs_wr[i].row, obs_wr[i].panel}), 64'({exp_wr[i].row, exp_wr[i].panel}));
    end
    check("n_events", 64'(obs_ev.size()), 64'(exp_ev.size()));
    for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++)
      check("event_kind", 64'(obs_ev[i]), 64'(exp_ev[i]));
    check("state_hunt_after_seg", 64'(state_out), 64'(0));
  endtask

  function automatic bq_t good_frame(input logic [7:0] addr, input logic [7:0] ck_flip);
    bq_t s;
    logic [7:0] ck = addr;
    s.push_back(SYNC);
    s.push_back(addr);
    for (int b = 0; b < CB*CPR; b++) begin
      s.push_back(8'(b));
      ck = ck ^ 8'(b);
    end
`ifdef USB_RX_CHECKSUM_EN
    s.push_back(ck ^ ck_flip);
`else
    if (ck_flip != 8'h00) s.push_back(8'h00);
`endif
    return s;
  endfunction

  initial begin
    #1_900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    bq_t  s;
    int   n, f0, w0;
    logic [7:0] a, ck;

    tbl[0] = '{8'h06, 1'b1, 4'd6,  2'd0};
    tbl[1] = '{8'hC0, 1'b0, 4'd6,  2'd0};
    tbl[2] = '{8'h21, 1'b1, 4'd1,  2'd2};
    tbl[3] = '{8'h40, 1'b0, 4'd1,  2'd2};
    tbl[4] = '{8'h3F, 1'b1, 4'd15, 2'd3};
    tbl[5] = '{8'h80, 1'b0, 4'd15, 2'd3};
    tbl[6] = '{8'h00, 1'b1, 4'd0,  2'd0};
    tbl[7] = '{8'hA5, 1'b0, 4'd0,  2'd0};

    // Reset held with the FIFO reporting data.
    reset_n = 1'b0;
    s = {8'h00, 8'hFF};
    push_bytes(s);
    repeat (6) @(negedge clk);
    check("rst_rd_n", 64'(rd_n), 64'(1));
    check("rst_we", 64'(chunk_write_enable), 64'(0));
    check("rst_data", 64'(chunk_data), 64'(0));
    check("rst_chunk_addr", 64'(chunk_addr), 64'(0));
    check("rst_row_panel", 64'({row_addr, panel_addr}), 64'(0));
    check("rst_done_err", 64'({frame_done, frame_error}), 64'(0));
    check("rst_state", 64'(state_out), 64'(0));
    obs_wr.delete(); obs_ev.delete();
    reset_n = 1'b1;
    wait_drain(500, 1'b0);
    check("garbage_no_writes", 64'(obs_wr.size()), 64'(0));
    check("garbage_no_events", 64'(obs_ev.size()), 64'(0));

    for (int t = 0; t < 8; t++) begin
      s = {};
      if (tbl[t].ok) s = good_frame(tbl[t].addr, 8'h00);
      else begin s.push_back(SYNC); s.push_back(tbl[t].addr); end
      run_seg(s, 1'b0);
      check("tbl_writes", 64'(obs_wr.size()), tbl[t].ok ? 64'(CPR) : 64'(0));
      check("tbl_event", (obs_ev.size() == 1) ? 64'(obs_ev[0]) : 64'(99), tbl[t].ok ? 64'(0) : 64'(1));
      check("tbl_row", 64'(row_addr), 64'(tbl[t].row));
      check("tbl_panel", 64'(panel_addr), 64'(tbl[t].panel));
      if (tbl[t].ok && obs_wr.size() == CPR) begin
        check("tbl_chunk0", 64'({obs_wr[0].addr, obs_wr[0].data}), {28'h0, 4'd0, 32'h00010203});
        check("tbl_chunk15", 64'({obs_wr[CPR-1].addr, obs_wr[CPR-1].data}), {28'h0, 4'd15, 32'h3C3D3E3F});
      end
    end

    // Leading junk before the sync byte.
    s = good_frame(8'h21, 8'h00);
    s.push_front(8'hFF);
    s.push_front(8'h00);
    run_seg(s, 1'b0);
    check("junk_writes", 64'(obs_wr.size()), 64'(CPR));
    check("junk_row_panel", 64'({row_addr, panel_addr}), 64'({4'd1, 2'd2}));

    // FIFO empty for 50 cycles after the tenth payload byte.
    s = good_frame(8'h06, 8'h00);
    pause_at = pops + 12;
    fork
      run_seg(s, 1'b0);
      begin
        n = 0;
        while (pops < pause_at && n < 5000) begin @(negedge clk); n++; end
        f0 = falls;
        w0 = obs_wr.size();
        n = 0;
        while (pause_left > 0 && n < 200) begin @(negedge clk); n++; end
        check("pause_length", 64'(n >= 45), 64'(1));
        check("pause_no_reads", 64'(falls - f0), 64'(0));
        check("pause_no_writes", 64'(obs_wr.size() - w0), 64'(0));
      end
    join
    pause_at = -1;
    check("pause_writes_total", 64'(obs_wr.size()), 64'(CPR));

`ifdef USB_RX_CHECKSUM_EN
    s = good_frame(8'h06, 8'h01);
    run_seg(s, 1'b0);
    check("bad_cksum_writes", 64'(obs_wr.size()), 64'(CPR));
    check("bad_cksum_event", (obs_ev.size() == 1) ? 64'(obs_ev[0]) : 64'(99), 64'(1));
`endif

    for (int seg = 0; seg < 15; seg++) begin
      s = {};
      for (int fr = 0; fr < 2; fr++) begin
        n = $urandom_range(0, 3);
        for (int g = 0; g < n; g++) begin
          a = 8'($urandom);
          if (a == SYNC) a = 8'h5A;
          s.push_back(a);
        end
        s.push_back(SYNC);
        if ($urandom_range(0, 3) == 0) a = {2'($urandom_range(1, 3)), 6'($urandom)};
        else a = {2'b00, 6'($urandom)};
        s.push_back(a);
        if (a[7:6] == 2'b00) begin
          ck = a;
          for (int b = 0; b < CB*CPR; b++) begin
            s.push_back(8'($urandom));
            ck = ck ^ s[s.size()-1];
          end
`ifdef USB_RX_CHECKSUM_EN
          s.push_back(($urandom_range(0, 2) == 0) ? ck ^ 8'($urandom_range(1, 255)) : ck);
`endif
        end
      end
      run_seg(s, 1'b1);
    end

    check("state_code_valid", 64'(bad_state), 64'(0));
    check("done_err_exclusive", 64'(both_seen), 64'(0));

    // Reset asserted mid-read must release rd_n at once.
    s = {8'h11, 8'h22};
    push_bytes(s);
    n = 0;
    while (rd_n && n < 200) begin @(negedge clk); n++; end
    check("mid_read_started", 64'(rd_n), 64'(0));
    #2 reset_n = 1'b0;
    #1;
    check("mid_read_reset_rd_n", 64'(rd_n), 64'(1));
    check("mid_read_reset_state", 64'(state_out), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/usb_rx_framer.md
Name: usb_rx_framer

Overview:
Parametrised successor to the cube's USB receive path. Drains an FT245-style async FIFO (rxf_n/rd_n handshake) through input synchronisers, hunts for a sync byte, decodes a panel/row address byte and assembles payload bytes into CHUNK_BYTES-wide chunks. Each chunk is written to the row buffer with a one-cycle write strobe. Sits between the USB FIFO pins and the panel row RAMs; chunk width, chunks per row, address widths and strobe timing are generalised.

Parameters:
CHUNK_BYTES, 4, bytes per chunk; chunk_data width = 8*CHUNK_BYTES
CHUNKS_PER_ROW, 16, chunks per frame (power of two, >=2)
ROW_ADDR_W, 4, row address width
PANEL_ADDR_W, 2, panel address width; ROW_ADDR_W+PANEL_ADDR_W <= 8
RD_PULSE, 3, rd_n low time in clk cycles (>=3)
RD_GAP, 2, minimum rd_n high time between reads (>=1)
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous active-low reset
rxf_n_raw  in  1  FIFO not-empty, active low, asynchronous
data_bus_in_raw  in  8  FIFO data, asynchronous
rd_n  out  1  FIFO read strobe, active low
chunk_data  out  8*CHUNK_BYTES  assembled chunk, first byte in MSBs
chunk_addr  out  log2(CHUNKS_PER_ROW)  chunk index within row
chunk_write_enable  out  1  one-cycle write strobe
row_addr  out  ROW_ADDR_W  row from address byte
panel_addr  out  PANEL_ADDR_W  panel from address byte
frame_done  out  1  one-cycle pulse, frame complete
frame_error  out  1  one-cycle pulse, frame aborted
state_out  out  3  frame phase: 0 HUNT,1 ADDR,2 PAYLOAD,3 CKSUM,4 DONE

Behaviour:
- Reset (asynchronous, active low): rd_n=1, all other outputs 0, state HUNT, synchronisers cleared. Reset mid-read releases rd_n immediately; the partially read byte is lost.
- rxf_n_raw and data_bus_in_raw pass through 2-flop synchronisers before any use.
- Byte reader: when idle and synced rxf_n==0, rd_n falls on the next clock edge. It stays low exactly RD_PULSE cycles. Synced data is captured on the last low cycle. rd_n then stays high for at least RD_GAP cycles before synced rxf_n is re-examined. One captured byte yields one internal byte_valid pulse.
- HUNT: bytes != SYNC_BYTE are discarded. SYNC_BYTE -> ADDR.
- ADDR: row = byte[ROW_ADDR_W-1:0], panel = next PANEL_ADDR_W bits.
  - Any nonzero bit above these -> frame_error pulse, back to HUNT, row_addr/panel_addr unchanged.
  - Otherwise latch row_addr/panel_addr, byte and chunk counters = 0 -> PAYLOAD.
- PAYLOAD: bytes shift into the chunk register MSB-first. On the CHUNK_BYTES-th byte, the next cycle:
  - chunk_write_enable=1 for one cycle.
  - chunk_data, chunk_addr, row_addr and panel_addr are stable during the strobe.
  - chunk counter increments.
- After chunk CHUNKS_PER_ROW-1 is written: DONE (or CKSUM if enabled).
- DONE: frame_done pulses one cycle, then HUNT.
- A SYNC_BYTE inside the payload is data, not resync.
- FIFO empty mid-frame: the block waits indefinitely, with no timeout.
- chunk_addr wraps naturally, but it never exceeds CHUNKS_PER_ROW-1 within a frame.
- frame_done and frame_error are never asserted together.
- Latency: the last byte captured -> chunk_write_enable is 1 cycle; the last chunk strobe -> frame_done is 1 cycle.

Optional Feature:
USB_RX_CHECKSUM_EN:
- Defined: after the payload, one extra byte is read in CKSUM.
- It must equal the XOR of the address byte and all payload bytes. Match -> frame_done; mismatch -> frame_error. Either way, return to HUNT.
- Chunks are already written and are not rolled back.
- Undefined: CKSUM is never entered and state_out never shows 3.

Test Plan:
1. Reset held, rxf_n_raw=0 -> rd_n stays 1, all outputs 0. Release reset -> the first rd_n low pulse is exactly 3 cycles, and the next falling edge is at least 2 high cycles later.
2. Stream A5,06, then 64 bytes 00..3F (defaults) -> 16 write strobes. Chunk 0 = 32'h00010203 at addr 0, chunk 15 = 32'h3C3D3E3F. row_addr=6, panel_addr=0. frame_done pulses once, 1 cycle after the last strobe.
3. Stream 00,FF,A5,21,... -> 00 and FF are ignored. Frame decodes with row=1, panel=2.
4. Stream A5,C0 -> frame_error pulse, no write strobes, state_out returns to 0.
5. rxf_n_raw high for 50 cycles after payload byte 10 -> rd_n held high, no strobes. Resuming completes the frame with correct data.
6. USB_RX_CHECKSUM_EN: a correct XOR byte -> frame_done. Corrupting it by 8'h01 -> frame_error, and all 16 chunk strobes are still observed.
